aes_key_schedule_seq: RTL
=========================

Name: aes_key_schedule_seq

Overview:
- Iterative AES key-expansion engine. Sits directly upstream of the round datapath and supplies one 128-bit round key per request.
- Captures the cipher key on a start pulse and generates one 32-bit schedule word per clock into an internal word buffer.
- Serves round keys through an indexed, registered read port once expansion completes.
- Replaces the fully combinational expansion so that area is bounded and expansion latency is explicit.

Parameters:
- NK, 6, key length in 32-bit words; legal values 4, 6, 8.
- NR, NK+6, number of rounds; derived, not overridable.
- NW, 4*(NR+1), total schedule words (44/52/60).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin expansion; honoured only in IDLE or DONE.
- key_in  input  256  cipher key, left-aligned; bits [255 -: 32*NK] are used, the rest are ignored; w[0] = key_in[255:224].
- busy  output  1  high while in EXPAND.
- done  output  1  high in DONE; round keys valid.
- rk_idx  input  4  round-key index, 0..NR.
- rk_out  output  128  round key {w[4r], w[4r+1], w[4r+2], w[4r+3]} with w[4r] in bits [127:96]; registered.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, busy=0, done=0, rk_out=0, word counter=0, rcon=8'h01. Word buffer contents are not cleared.
- Reset has priority over every other input, including mid-expansion; the schedule is abandoned.
- States and transitions:
  - IDLE: on start, capture w[0..NK-1] from key_in in that same edge, set i=NK, j=0 (i mod NK), rcon=01, go to EXPAND.
  - EXPAND: one word per edge. temp=w[i-1].
    - If j==0: temp=SubWord(RotWord(temp)) xor {rcon,24'h0}; after use, rcon=xtime(rcon).
    - Else if NK==8 and j==4: temp=SubWord(temp).
    - Write w[i]=w[i-NK] xor temp; then i++, j = (j==NK-1) ? 0 : j+1.
    - No divider and no Rcon ROM. The rcon sequence is 01,02,04,08,10,20,40,80,1b,36.
    - After writing w[NW-1], go to DONE.
  - DONE: done=1. A new start re-enters EXPAND exactly as from IDLE, with done dropping on that edge.
- start during EXPAND is ignored; key_in is sampled only on the accepting edge.
- Latency: done is first high after edge k+(NW-NK) when start is accepted at edge k. That is 40/46/52 cycles for NK=4/6/8.
- busy and done are never both high. Both are low only in IDLE.
- SubWord uses four instances of the team's forward byte S-box. RotWord is {b1,b2,b3,b0}.
- Read port: rk_out updates every edge.
  - rk_out = round key rk_idx if done=1 and rk_idx<=NR; otherwise 128'h0.
  - One-cycle latency from rk_idx to rk_out.
  - When done falls, rk_out reads 0 from the following edge.
- Round 0 key equals the cipher key (NK=4), or its first 128 bits (NK=6,8).

Test Plan:
- NK=4, key 2b7e151628aed2a6abf7158809cf4f3c, start 1 cycle:
  - done high after exactly 40 edges, busy high during those 40.
  - rk_idx=1 gives rk_out=a0fafe1788542cb123a339392a6c7605 the next cycle.
  - rk_idx=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
- NK=6, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - done after 46 edges.
  - rk_idx=12 gives e98ba06f448c773c8ecc720401002202.
  - rk_idx=0 gives 8e73b0f7da0e6452c810f32b809079e5.
- NK=8, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - done after 52 edges.
  - rk_idx=14 gives fe4890d1e6188d0b046df344706c631e (exercises the j==4 SubWord path).
- Control edge cases:
  - start re-pulsed mid-EXPAND with a different key: ignored; final keys match the first key and the done cycle count is unchanged.
  - rk_idx=NR+1 while done: rk_out=0.
  - rk_idx read while busy: rk_out=0.
- Reset and restart:
  - rst asserted 20 cycles into EXPAND: next edge busy=0, done=0, rk_out=0.
  - A fresh start then produces correct keys with full latency.
  - In DONE, start with a new key: done drops on the accepting edge, re-asserts after NW-NK edges, and keys match the new vector.

Source files
------------

// File: rtl/aes_key_schedule_seq_if.sv
// Request/response bundle between the round datapath and the AES key-schedule engine.
// The master starts expansion and reads round keys; the slave is the schedule engine.
interface aes_key_schedule_seq_if;
  logic         start;
  logic [255:0] key_in;
  logic         busy;
  logic         done;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;

  modport master (output start, key_in, rk_idx, input busy, done, rk_out);
  modport slave  (input start, key_in, rk_idx, output busy, done, rk_out);
endinterface

// File: rtl/aes_key_schedule_seq.sv
// Iterative AES key expansion: one schedule word per clock into a word buffer,
// round keys served through a registered indexed read port once expansion is done.

// Forward AES byte S-box built from the field inverse (x^254) and the affine map.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = x;
    for (int k = 0; k < 8; k++) begin
      if (z[k]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] pw;
  logic [7:0] inv;

  // inv = a^2 * a^4 * ... * a^128 = a^254, which also maps 0 to 0
  always_comb begin
    pw  = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      pw  = gf_mul(pw, pw);
      inv = gf_mul(inv, pw);
    end
    y = inv
      ^ {inv[6:0], inv[7]}
      ^ {inv[5:0], inv[7:6]}
      ^ {inv[4:0], inv[7:5]}
      ^ {inv[3:0], inv[7:4]}
      ^ 8'h63;
  end
endmodule

module aes_key_schedule_seq #(
  parameter int NK = 6
) (
  input logic clk,
  input logic rst,
  aes_key_schedule_seq_if.slave bus
);
  localparam int         NR     = NK + 6;
  localparam int         NW     = 4 * (NR + 1);
  localparam logic [5:0] NK_W   = 6'(NK);
  localparam logic [5:0] LAST_W = 6'(NW - 1);
  localparam logic [2:0] J_LAST = 3'(NK - 1);
  localparam logic [3:0] NR_W   = 4'(NR);

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_e;

  state_e       state_q, state_d;
  logic [5:0]   i_q, i_d;
  logic [2:0]   j_q, j_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [31:0]  w_q [NW];
  logic [31:0]  w_d [NW];
  logic [127:0] rk_out_q, rk_out_d;

  logic        accept;
  logic [31:0] prev_word;
  logic [31:0] sub_in;
  logic [31:0] sub_out;
  logic [31:0] temp;
  logic [31:0] new_word;
  logic        key_unused;

  // Short keys leave the low bits of key_in unused by design.
  assign key_unused = ^bus.key_in;

  assign accept = bus.start && (state_q != EXPAND);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXPAND;
      EXPAND:  if (i_q == LAST_W) state_d = DONE;
      DONE:    if (accept) state_d = EXPAND;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q == EXPAND);
    bus.done = (state_q == DONE);
  end

  // RotWord is applied ahead of the shared S-boxes only on the j==0 step
  always_comb begin
    prev_word = w_q[i_q - 6'd1];
    sub_in    = (j_q == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
    temp      = prev_word;
    if (j_q == 3'd0)                   temp = sub_out ^ {rcon_q, 24'h000000};
    else if (NK == 8 && j_q == 3'd4)   temp = sub_out;
    new_word  = w_q[i_q - NK_W] ^ temp;
  end

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .a (sub_in[8*g +: 8]),
      .y (sub_out[8*g +: 8])
    );
  end

  always_comb begin
    i_d    = i_q;
    j_d    = j_q;
    rcon_d = rcon_q;
    if (accept) begin
      i_d    = NK_W;
      j_d    = 3'd0;
      rcon_d = 8'h01;
    end else if (state_q == EXPAND) begin
      i_d = i_q + 6'd1;
      j_d = (j_q == J_LAST) ? 3'd0 : j_q + 3'd1;
      if (j_q == 3'd0) rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
    end
  end

  always_comb begin
    w_d = w_q;
    if (accept) begin
      for (int k = 0; k < NK; k++) w_d[6'(k)] = bus.key_in[255 - 32*k -: 32];
    end else if (state_q == EXPAND) begin
      w_d[i_q] = new_word;
    end
  end

  always_comb begin
    rk_out_d = '0;
    if (state_q == DONE && bus.rk_idx <= NR_W) begin
      rk_out_d = {w_q[{bus.rk_idx, 2'b00}], w_q[{bus.rk_idx, 2'b01}],
                  w_q[{bus.rk_idx, 2'b10}], w_q[{bus.rk_idx, 2'b11}]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_q      <= '0;
      j_q      <= '0;
      rcon_q   <= 8'h01;
      rk_out_q <= '0;
    end else begin
      i_q      <= i_d;
      j_q      <= j_d;
      rcon_q   <= rcon_d;
      rk_out_q <= rk_out_d;
    end
  end

  // The word buffer is deliberately left out of reset.
  always_ff @(posedge clk) begin
    w_q <= w_d;
  end

  assign bus.rk_out = rk_out_q;
endmodule
